// File: rtl/rl_sched_pkg.sv
// Shared definitions for the LJ cell scheduler and the motion-update block:
// scheduler state encoding and default simulation-box dimensions.
package rl_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EVAL_ISSUE = 3'd1,
        ST_EVAL_WAIT  = 3'd2,
        ST_NEXT_CELL  = 3'd3,
        ST_MU_ISSUE   = 3'd4,
        ST_MU_WAIT    = 3'd5,
        ST_STEP_END   = 3'd6
    } sched_state_e;

    localparam int DEF_CELL_ID_WIDTH   = 4;
    localparam int DEF_X_CELLS         = 9;
    localparam int DEF_Y_CELLS         = 9;
    localparam int DEF_Z_CELLS         = 7;
    localparam int DEF_TSTEP_WIDTH     = 16;
    localparam int DEF_WATCHDOG_CYCLES = 65535;
    localparam int DEF_WD_WIDTH        = 16;

endpackage

// File: rtl/rl_lj_cell_scheduler_if.sv
// Control bus between the cell scheduler (master), its host, the LJ engine
// and the motion-update unit (slave side).
interface rl_lj_cell_scheduler_if
    import rl_sched_pkg::*;
#(
    parameter int CELL_ID_WIDTH = DEF_CELL_ID_WIDTH,
    parameter int TSTEP_WIDTH   = DEF_TSTEP_WIDTH
);
    // start is a level sampled only while idle; eval_start and mu_start are
    // one-cycle requests; eval_done is a level that holds until the next
    // eval_start; mu_done is a one-cycle completion pulse.
    logic                     start;
    logic [TSTEP_WIDTH-1:0]   cfg_num_timesteps;
    logic                     eval_start;
    logic [CELL_ID_WIDTH-1:0] home_cell_x;
    logic [CELL_ID_WIDTH-1:0] home_cell_y;
    logic [CELL_ID_WIDTH-1:0] home_cell_z;
    logic                     eval_done;
    logic                     mu_start;
    logic                     mu_done;
    logic [TSTEP_WIDTH-1:0]   cur_timestep;
    logic                     busy;
    logic                     run_done;
    logic                     error;
    sched_state_e             dbg_state;

    modport master (
        input  start, cfg_num_timesteps, eval_done, mu_done,
        output eval_start, home_cell_x, home_cell_y, home_cell_z, mu_start,
               cur_timestep, busy, run_done, error, dbg_state
    );

    modport slave (
        output start, cfg_num_timesteps, eval_done, mu_done,
        input  eval_start, home_cell_x, home_cell_y, home_cell_z, mu_start,
               cur_timestep, busy, run_done, error, dbg_state
    );

endinterface

// File: rtl/rl_cell_counter.sv
// 3-D wrapping cell counter, Z fastest then Y then X; o_last flags the final
// cell of the box so the caller can act before the wrap to (0,0,0).
module rl_cell_counter
    import rl_sched_pkg::*;
#(
    parameter int W  = DEF_CELL_ID_WIDTH,
    parameter int XN = DEF_X_CELLS,
    parameter int YN = DEF_Y_CELLS,
    parameter int ZN = DEF_Z_CELLS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_y,
    output logic [W-1:0] o_z,
    output logic         o_last
);

    logic [W-1:0] r_x, r_y, r_z;
    logic         w_x_last, w_y_last, w_z_last;

    assign w_x_last = (r_x == W'(XN - 1));
    assign w_y_last = (r_y == W'(YN - 1));
    assign w_z_last = (r_z == W'(ZN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (i_inc) begin
            if (w_z_last) begin
                r_z <= '0;
                if (w_y_last) begin
                    r_y <= '0;
                    r_x <= w_x_last ? '0 : r_x + 1'b1;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_z <= r_z + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_z    = r_z;
    assign o_last = w_x_last & w_y_last & w_z_last;

endmodule

// File: rtl/rl_lj_cell_scheduler.sv
// Top-level sequencer: issues one engine start per home cell, then a motion
// update, for a programmed number of timesteps, with a per-wait watchdog.
module rl_lj_cell_scheduler
    import rl_sched_pkg::*;
#(
    parameter int CELL_ID_WIDTH   = DEF_CELL_ID_WIDTH,
    parameter int X_CELLS         = DEF_X_CELLS,
    parameter int Y_CELLS         = DEF_Y_CELLS,
    parameter int Z_CELLS         = DEF_Z_CELLS,
    parameter int TSTEP_WIDTH     = DEF_TSTEP_WIDTH,
    parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES,
    parameter int WD_WIDTH        = DEF_WD_WIDTH
) (
    input logic                    clk,
    input logic                    rst,
    rl_lj_cell_scheduler_if.master bus
);

    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(WATCHDOG_CYCLES - 1);

    sched_state_e             r_state, w_state_nxt;
    logic                     r_eval_done_q;
    logic [TSTEP_WIDTH-1:0]   r_cfg, r_ts;
    logic [WD_WIDTH-1:0]      r_wd;
    logic                     r_eval_start, r_mu_start, r_busy, r_run_done, r_error;
    logic                     w_done_rise, w_wd_expire;
    logic                     w_cfg_load, w_cnt_clr, w_cnt_inc;
    logic                     w_ts_clr, w_ts_inc, w_wd_clr, w_wd_inc;
    logic                     w_err_set, w_err_clr, w_run_done_nxt;
    logic [CELL_ID_WIDTH-1:0] w_cell_x, w_cell_y, w_cell_z;
    logic                     w_cell_last;

    // A done level that is already high on entry to EVAL_WAIT is stale; only a fresh rise counts.
    assign w_done_rise = bus.eval_done & ~r_eval_done_q;
    assign w_wd_expire = (r_wd == WD_LAST);

    rl_cell_counter #(
        .W  (CELL_ID_WIDTH),
        .XN (X_CELLS),
        .YN (Y_CELLS),
        .ZN (Z_CELLS)
    ) u_cell_counter (
        .clk    (clk),
        .rst_n  (rst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_x    (w_cell_x),
        .o_y    (w_cell_y),
        .o_z    (w_cell_z),
        .o_last (w_cell_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cfg_load     = 1'b0;
        w_cnt_clr      = 1'b0;
        w_cnt_inc      = 1'b0;
        w_ts_clr       = 1'b0;
        w_ts_inc       = 1'b0;
        w_wd_clr       = 1'b0;
        w_wd_inc       = 1'b0;
        w_err_set      = 1'b0;
        w_err_clr      = 1'b0;
        w_run_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_cfg_load  = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_ts_clr    = 1'b1;
                    w_wd_clr    = 1'b1;
                    w_err_clr   = 1'b1;
                    w_state_nxt = (bus.cfg_num_timesteps == '0) ? ST_STEP_END : ST_EVAL_ISSUE;
                end
            end
            ST_EVAL_ISSUE: begin
                w_wd_clr    = 1'b1;
                w_state_nxt = ST_EVAL_WAIT;
            end
            ST_EVAL_WAIT: begin
                if (w_done_rise) begin
                    w_state_nxt = ST_NEXT_CELL;
                end else if (w_wd_expire) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            ST_NEXT_CELL: begin
                w_cnt_inc   = 1'b1;
                w_state_nxt = w_cell_last ? ST_MU_ISSUE : ST_EVAL_ISSUE;
            end
            ST_MU_ISSUE: begin
                w_wd_clr    = 1'b1;
                w_state_nxt = ST_MU_WAIT;
            end
            ST_MU_WAIT: begin
                if (bus.mu_done) begin
                    w_ts_inc    = 1'b1;
                    w_state_nxt = ST_STEP_END;
                end else if (w_wd_expire) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            ST_STEP_END: begin
                if (r_ts == r_cfg) begin
                    w_run_done_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EVAL_ISSUE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state; busy stays up through the run_done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eval_done_q <= 1'b0;
            r_cfg         <= '0;
            r_ts          <= '0;
            r_wd          <= '0;
            r_error       <= 1'b0;
            r_eval_start  <= 1'b0;
            r_mu_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_run_done    <= 1'b0;
        end else begin
            r_eval_done_q <= bus.eval_done;
            if (w_cfg_load) r_cfg <= bus.cfg_num_timesteps;
            if (w_ts_clr)      r_ts <= '0;
            else if (w_ts_inc) r_ts <= r_ts + 1'b1;
            if (w_wd_clr)      r_wd <= '0;
            else if (w_wd_inc) r_wd <= r_wd + 1'b1;
            if (w_err_clr)      r_error <= 1'b0;
            else if (w_err_set) r_error <= 1'b1;
            r_eval_start <= (w_state_nxt == ST_EVAL_ISSUE);
            r_mu_start   <= (w_state_nxt == ST_MU_ISSUE);
            r_busy       <= (w_state_nxt != ST_IDLE) | w_run_done_nxt;
            r_run_done   <= w_run_done_nxt;
        end
    end

    assign bus.eval_start   = r_eval_start;
    assign bus.mu_start     = r_mu_start;
    assign bus.home_cell_x  = w_cell_x;
    assign bus.home_cell_y  = w_cell_y;
    assign bus.home_cell_z  = w_cell_z;
    assign bus.cur_timestep = r_ts;
    assign bus.busy         = r_busy;
    assign bus.run_done     = r_run_done;
    assign bus.error        = r_error;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_rl_lj_cell_scheduler.sv
// Directed bench for rl_lj_cell_scheduler on a 2x2x2 box with a 20-cycle
// watchdog: table-driven full runs plus hand-written corner sequences.
module tb_rl_lj_cell_scheduler;
    import rl_sched_pkg::*;

    localparam int CW      = 4;
    localparam int TW      = 16;
    localparam int NX      = 2;
    localparam int NY      = 2;
    localparam int NZ      = 2;
    localparam int WD      = 20;
    localparam int ENG_LAT = 5;
    localparam int MU_LAT  = 3;

    typedef struct {
        int cfg;
        int inj_start;
        int exp_evals;
        int exp_mus;
        int exp_ts;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rl_lj_cell_scheduler_if #(.CELL_ID_WIDTH(CW), .TSTEP_WIDTH(TW)) bus ();

    rl_lj_cell_scheduler #(
        .CELL_ID_WIDTH   (CW),
        .X_CELLS         (NX),
        .Y_CELLS         (NY),
        .Z_CELLS         (NZ),
        .TSTEP_WIDTH     (TW),
        .WATCHDOG_CYCLES (WD),
        .WD_WIDTH        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [3*CW-1:0] exp_q[$];
    logic [TW-1:0]   exp_ts_q[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int pend = -1;
    int ev_cnt, mu_cnt, rd_cnt, rd_cyc, busy_rise, busy_fall;
    int eng_cnt = 0;
    int mu_dn = 0;
    bit rd_wide, rd_prev, busy_prev;
    bit eng_en = 0;
    bit mon_en = 0;

    function automatic logic [3*CW-1:0] pack(int x, int y, int z);
        logic [CW-1:0] lx, ly, lz;
        lx = CW'(x);
        ly = CW'(y);
        lz = CW'(z);
        return {lx, ly, lz};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3*CW-1:0] cur_cell();
        return {bus.home_cell_x, bus.home_cell_y, bus.home_cell_z};
    endfunction

    // One clock: sample outputs at the falling edge, then drive the engine model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.eval_start) begin
            ev_cnt++;
            if (mon_en) begin
                chk("cell_avail", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("cell", 32'(cur_cell()), 32'(exp_q.pop_front()));
                chk("eval_lat", cyc, pend);
            end
            pend = -1;
        end
        if (bus.mu_start) begin
            mu_cnt++;
            if (mon_en) begin
                chk("ts_avail", 32'(exp_ts_q.size() > 0), 1);
                if (exp_ts_q.size() > 0) chk("ts_at_mu", 32'(bus.cur_timestep), 32'(exp_ts_q.pop_front()));
                chk("mu_lat", cyc, pend);
            end
            pend = -1;
        end
        if (bus.run_done) begin
            rd_cnt++;
            rd_cyc = cyc;
            if (rd_prev) rd_wide = 1'b1;
            if (mon_en) chk("rd_lat", cyc, pend);
            pend = -1;
        end
        rd_prev = bus.run_done;
        if (bus.busy && !busy_prev) busy_rise = cyc;
        if (!bus.busy && busy_prev) busy_fall = cyc;
        busy_prev = bus.busy;
        if (eng_en) begin
            bus.mu_done = 1'b0;
            if (bus.eval_start) begin
                bus.eval_done = 1'b0;
                eng_cnt = ENG_LAT;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.eval_done = 1'b1;
                    pend = cyc + 2;
                end
            end
            if (bus.mu_start) begin
                mu_dn = MU_LAT;
            end else if (mu_dn > 0) begin
                mu_dn--;
                if (mu_dn == 0) begin
                    bus.mu_done = 1'b1;
                    pend = cyc + 2;
                end
            end
        end
    endtask

    task automatic clear_counts();
        ev_cnt = 0; mu_cnt = 0; rd_cnt = 0; rd_cyc = -1;
        busy_rise = -1; busy_fall = -1; rd_wide = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.eval_done = 1'b0;
        bus.mu_done = 1'b0;
        tick();
    endtask

    // ---------------- test ----------------
    vec_t tbl[4];
    int t0, k, n0;

    initial begin
        tbl[0] = '{cfg: 1, inj_start: 0, exp_evals: 8,  exp_mus: 1, exp_ts: 1};
        tbl[1] = '{cfg: 3, inj_start: 0, exp_evals: 24, exp_mus: 3, exp_ts: 3};
        tbl[2] = '{cfg: 0, inj_start: 0, exp_evals: 0,  exp_mus: 0, exp_ts: 0};
        tbl[3] = '{cfg: 2, inj_start: 1, exp_evals: 16, exp_mus: 2, exp_ts: 2};

        rst = 1'b0;
        bus.start = 1'b0;
        bus.cfg_num_timesteps = '0;
        bus.eval_done = 1'b0;
        bus.mu_done = 1'b0;
        clear_counts();
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_eval_start", 32'(bus.eval_start), 0);
        chk("rst_mu_start", 32'(bus.mu_start), 0);
        chk("rst_run_done", 32'(bus.run_done), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_cell", 32'(cur_cell()), 0);
        chk("rst_ts", 32'(bus.cur_timestep), 0);
        rst = 1'b1;
        tick();

        // Stale done: level held high across the next eval_start must not advance.
        bus.cfg_num_timesteps = 1;
        bus.start = 1'b1;
        t0 = cyc;
        tick();
        bus.start = 1'b0;
        chk("stale_ev0", 32'(bus.eval_start), 1);
        chk("stale_cell0", 32'(cur_cell()), 32'(pack(0, 0, 0)));
        chk("busy_rise_t1", 32'(bus.busy), 1);
        while (cyc < t0 + 4) tick();
        bus.eval_done = 1'b1;
        tick();
        tick();
        chk("stale_ev1", 32'(bus.eval_start), 1);
        chk("stale_cell1", 32'(cur_cell()), 32'(pack(0, 0, 1)));
        n0 = ev_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) bus.mu_done = 1'b1;
            tick();
            bus.mu_done = 1'b0;
        end
        chk("stale_hold_evs", ev_cnt - n0, 0);
        chk("stale_hold_state", 32'(bus.dbg_state), 32'(ST_EVAL_WAIT));
        chk("stale_hold_cell", 32'(cur_cell()), 32'(pack(0, 0, 1)));
        bus.eval_done = 1'b0;
        tick();
        bus.eval_done = 1'b1;
        n0 = ev_cnt;
        tick();
        tick();
        chk("stale_rerise_ev", 32'(bus.eval_start), 1);
        chk("stale_rerise_cnt", ev_cnt - n0, 1);
        chk("stale_rerise_cell", 32'(cur_cell()), 32'(pack(0, 1, 0)));
        do_reset();

        // Watchdog: eval_done never rises.
        clear_counts();
        bus.start = 1'b1;
        t0 = cyc;
        tick();
        bus.start = 1'b0;
        while (cyc < t0 + 21) tick();
        chk("wd_err_before", 32'(bus.error), 0);
        chk("wd_busy_before", 32'(bus.busy), 1);
        tick();
        chk("wd_err", 32'(bus.error), 1);
        chk("wd_busy", 32'(bus.busy), 0);
        chk("wd_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        tick();
        tick();
        chk("wd_sticky", 32'(bus.error), 1);
        chk("wd_no_run_done", rd_cnt, 0);

        // Restart clears error; a done on the expiry cycle wins over the watchdog.
        bus.start = 1'b1;
        t0 = cyc;
        tick();
        bus.start = 1'b0;
        chk("wd_err_cleared", 32'(bus.error), 0);
        while (cyc < t0 + 21) tick();
        bus.eval_done = 1'b1;
        tick();
        chk("prio_err", 32'(bus.error), 0);
        chk("prio_busy", 32'(bus.busy), 1);
        chk("prio_state", 32'(bus.dbg_state), 32'(ST_NEXT_CELL));
        tick();
        chk("prio_ev", 32'(bus.eval_start), 1);
        chk("prio_cell", 32'(cur_cell()), 32'(pack(0, 0, 1)));
        tick();

        // Asynchronous reset mid-EVAL_WAIT, then restart from (0,0,0).
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_cell", 32'(cur_cell()), 0);
        chk("arst_ts", 32'(bus.cur_timestep), 0);
        chk("arst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("arst_outs", 32'({bus.eval_start, bus.mu_start, bus.run_done, bus.error}), 0);
        tick();
        rst = 1'b1;
        bus.eval_done = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_ev", 32'(bus.eval_start), 1);
        chk("restart_cell", 32'(cur_cell()), 32'(pack(0, 0, 0)));
        do_reset();

        // Table-driven full runs with the engine / motion-update model active.
        eng_en = 1'b1;
        mon_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            clear_counts();
            exp_q.delete();
            exp_ts_q.delete();
            for (int t = 0; t < tbl[r].cfg; t++) begin
                for (int x = 0; x < NX; x++)
                    for (int y = 0; y < NY; y++)
                        for (int z = 0; z < NZ; z++)
                            exp_q.push_back(pack(x, y, z));
                exp_ts_q.push_back(TW'(t));
            end
            bus.cfg_num_timesteps = TW'(tbl[r].cfg);
            bus.start = 1'b1;
            t0 = cyc;
            pend = (tbl[r].cfg == 0) ? t0 + 2 : t0 + 1;
            tick();
            bus.start = 1'b0;
            k = 0;
            while (rd_cnt == 0 && k < 2000) begin
                if (tbl[r].inj_start != 0 && k == 10) begin
                    bus.start = 1'b1;
                    bus.cfg_num_timesteps = 5;
                end
                tick();
                bus.start = 1'b0;
                k++;
            end
            chk("run_timeout", 32'(k < 2000), 1);
            tick();
            tick();
            tick();
            chk("run_evals", ev_cnt, tbl[r].exp_evals);
            chk("run_mus", mu_cnt, tbl[r].exp_mus);
            chk("run_ts", 32'(bus.cur_timestep), 32'(tbl[r].exp_ts));
            chk("run_done_cnt", rd_cnt, 1);
            chk("run_done_width", 32'(rd_wide), 0);
            chk("run_cells_left", exp_q.size(), 0);
            chk("run_busy_rise", busy_rise, t0 + 1);
            chk("run_busy_fall", busy_fall, rd_cyc + 1);
            chk("run_busy_end", 32'(bus.busy), 0);
            chk("run_error", 32'(bus.error), 0);
            chk("run_cell_wrap", 32'(cur_cell()), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
